// File: rtl/philv_multicycle_core.sv
// Multicycle RV32I-subset core with one request/ready memory port.
// Halts on ECALL/EBREAK, on unsupported encodings and on misaligned accesses.
module philv_multicycle_core #(
   parameter int unsigned          BUS_WIDTH = 32,
   parameter logic [BUS_WIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rstb,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [BUS_WIDTH-1:0] mem_addr,
   output logic [BUS_WIDTH-1:0] mem_wdata,
   input  logic [BUS_WIDTH-1:0] mem_rdata,
   input  logic                 mem_ready,
   output logic                 halted,
   output logic                 illegal,
   output logic [BUS_WIDTH-1:0] c
);

   if (BUS_WIDTH != 32) begin : g_width_check
      $error("philv_multicycle_core: BUS_WIDTH must be 32");
   end

   typedef enum logic [2:0] {
      S_RESET, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   state_t               state_q, state_d;
   logic [BUS_WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [BUS_WIDTH-1:0] imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
   logic [BUS_WIDTH-1:0] rf_q [32];
   logic [BUS_WIDTH-1:0] rf_d [32];
   logic                 illegal_q, illegal_d, halted_q, halted_d;
   logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [BUS_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

   logic [6:0]           opc, f7;
   logic [2:0]           f3;
   logic [4:0]           rs1, rs2, rd, shamt;
   logic [BUS_WIDTH-1:0] op2, alu_res, ls_addr, pc_plus4, br_target;
   logic                 legal, take;

   assign opc = ir_q[6:0];
   assign rd  = ir_q[11:7];
   assign f3  = ir_q[14:12];
   assign rs1 = ir_q[19:15];
   assign rs2 = ir_q[24:20];
   assign f7  = ir_q[31:25];

   assign pc_plus4  = pc_q + BUS_WIDTH'(4);
   assign ls_addr   = a_q + imm_q;
   assign take      = (f3 == 3'b000) ? (a_q == b_q) : (a_q != b_q);
   assign br_target = take ? (pc_q + imm_q) : pc_plus4;

   always_comb begin
      legal = 1'b0;
      case (opc)
         OPC_OP:     legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
         OPC_OPIMM: begin
            case (f3)
               3'b011:  legal = 1'b0;
               3'b001:  legal = (f7 == 7'h00);
               3'b101:  legal = (f7 == 7'h00) || (f7 == 7'h20);
               default: legal = 1'b1;
            endcase
         end
         OPC_LOAD, OPC_STORE: legal = (f3 == 3'b010);
         OPC_BRANCH: legal = (f3 == 3'b000) || (f3 == 3'b001);
         OPC_SYSTEM: legal = (f3 == 3'b000) && (ir_q[31:21] == '0) && (ir_q[19:7] == '0);
         default:    legal = 1'b0;
      endcase
   end

   // Arithmetic shift kept in its own branch so the signed operand is not
   // turned unsigned by a mixed-sign conditional expression.
   always_comb begin
      op2   = (opc == OPC_OP) ? b_q : imm_q;
      shamt = op2[4:0];
      case (f3)
         3'b000:  alu_res = (opc == OPC_OP && f7[5]) ? (a_q - op2) : (a_q + op2);
         3'b001:  alu_res = a_q << shamt;
         3'b010:  alu_res = {{(BUS_WIDTH-1){1'b0}}, $signed(a_q) < $signed(op2)};
         3'b011:  alu_res = {{(BUS_WIDTH-1){1'b0}}, a_q < op2};
         3'b100:  alu_res = a_q ^ op2;
         3'b101: begin
            if (f7[5]) alu_res = $signed(a_q) >>> shamt;
            else       alu_res = a_q >> shamt;
         end
         3'b110:  alu_res = a_q | op2;
         default: alu_res = a_q & op2;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      imm_d     = imm_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      rf_d      = rf_q;
      illegal_d = illegal_q;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d = (rs1 == 5'd0) ? '0 : rf_q[rs1];
            b_d = (rs2 == 5'd0) ? '0 : rf_q[rs2];
            case (opc)
               OPC_STORE:  imm_d = {{(BUS_WIDTH-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
               OPC_BRANCH: imm_d = {{(BUS_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7],
                                    ir_q[30:25], ir_q[11:8], 1'b0};
               default:    imm_d = {{(BUS_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
            endcase
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (!legal) begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               case (opc)
                  OPC_OP, OPC_OPIMM: begin
                     alu_d   = alu_res;
                     pc_d    = pc_plus4;
                     state_d = S_WB;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     if (ls_addr[1:0] != 2'b00) begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                     end else begin
                        alu_d   = ls_addr;
                        pc_d    = pc_plus4;
                        state_d = S_MEM;
                     end
                  end
                  OPC_BRANCH: begin
                     if (br_target[1:0] != 2'b00) begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                     end else begin
                        pc_d    = br_target;
                        state_d = S_FETCH;
                     end
                  end
                  default: state_d = S_HALT;
               endcase
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               if (ir_q[5]) begin
                  state_d = S_FETCH;
               end else begin
                  mdr_d   = mem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            if (rd != 5'd0) rf_d[rd] = (opc == OPC_LOAD) ? mdr_q : alu_q;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase

      // Bus outputs are registered from the next-state view so they are
      // valid from the first cycle of FETCH/MEM and hold until completion.
      mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
      mem_we_d    = (state_d == S_MEM) && ir_d[5];
      mem_addr_d  = (state_d == S_MEM) ? alu_d : pc_d;
      mem_wdata_d = b_d;
      halted_d    = (state_d == S_HALT);
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= S_RESET;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         imm_q       <= '0;
         alu_q       <= '0;
         mdr_q       <= '0;
         for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
         illegal_q   <= 1'b0;
         halted_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         a_q         <= a_d;
         b_q         <= b_d;
         imm_q       <= imm_d;
         alu_q       <= alu_d;
         mdr_q       <= mdr_d;
         rf_q        <= rf_d;
         illegal_q   <= illegal_d;
         halted_q    <= halted_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign halted    = halted_q;
   assign illegal   = illegal_q;
   assign c         = alu_q;

endmodule
